// File: rtl/seven_seg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver.
// Captures a hex word on update and multiplexes it one digit at a time.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [15:0] value,
  input  logic       update,
  input  logic       en,
  input  logic       blank_lz,
  input  logic [3:0] dp_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic [1:0] digit_idx
);

  localparam int PW =
    (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [15:0]   disp_reg;
  logic [3:0]    nib;
  logic [15:0]   hi;
  logic [6:0]    hex;
  logic          blank;
  logic          wrap;

  // hi holds the current digit and everything above it
  always_comb begin
    nib   = disp_reg[{idx, 2'b00} +: 4];
    hi    = disp_reg >> {idx, 2'b00};
    wrap  = (pre == LAST);
    blank = !en || (blank_lz && (idx != 2'd0) && (hi == 16'h0000));
  end

  always_comb begin
    hex = 7'b1111111;
    case (nib)
      4'h0: hex = 7'b1000000;
      4'h1: hex = 7'b1111001;
      4'h2: hex = 7'b0100100;
      4'h3: hex = 7'b0110000;
      4'h4: hex = 7'b0011001;
      4'h5: hex = 7'b0010010;
      4'h6: hex = 7'b0000010;
      4'h7: hex = 7'b1111000;
      4'h8: hex = 7'b0000000;
      4'h9: hex = 7'b0010000;
      4'hA: hex = 7'b0001000;
      4'hB: hex = 7'b0000011;
      4'hC: hex = 7'b1000110;
      4'hD: hex = 7'b0100001;
      4'hE: hex = 7'b0000110;
      4'hF: hex = 7'b0001110;
      default: hex = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre       <= '0;
      idx       <= 2'd0;
      disp_reg  <= 16'h0000;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
      digit_idx <= 2'd0;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (wrap)
        idx <= idx + 2'd1;
      if (update)
        disp_reg <= value;
      digit_idx <= idx;
      if (blank) begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= hex;
        dp  <= ~dp_en[idx];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with REFRESH_DIV=4.
// Expected patterns are hand-derived per output edge.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        update;
  logic        en;
  logic        blank_lz;
  logic [3:0]  dp_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int checks = 0;
  int failures = 0;

  localparam logic [3:0] AB = 4'b1111;
  localparam logic [6:0] SB = 7'b1111111;

  seven_seg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .update(update),
    .en(en),
    .blank_lz(blank_lz),
    .dp_en(dp_en),
    .seg(seg),
    .dp(dp),
    .an(an),
    .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [3:0] ea,
                         input logic [6:0] es,
                         input logic ed,
                         input logic [1:0] ei);
    chk({tag, ".an"}, 16'(an), 16'(ea));
    chk({tag, ".seg"}, 16'(seg), 16'(es));
    chk({tag, ".dp"}, 16'(dp), 16'(ed));
    chk({tag, ".idx"}, 16'(digit_idx), 16'(ei));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int n,
                     input logic [3:0] ea,
                     input logic [6:0] es,
                     input logic ed,
                     input logic [1:0] ei);
    for (int i = 0; i < n; i++) begin
      step();
      chk_out(tag, ea, es, ed, ei);
    end
  endtask

  initial begin
    reset = 1'b1;
    value = 16'h0000;
    update = 1'b0;
    en = 1'b1;
    blank_lz = 1'b0;
    dp_en = 4'b0000;
    #2;
    chk_out("rst", AB, SB, 1'b1, 2'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: first edge after release shows digit 0 of zero
    step();
    chk_out("rel", 4'b1110, 7'b1000000, 1'b1, 2'd0);

    // 2: capture 12C8 and scan a full cycle
    value = 16'h12C8;
    update = 1'b1;
    step();
    chk_out("upd", 4'b1110, 7'b1000000, 1'b1, 2'd0);
    update = 1'b0;
    run("s0", 2, 4'b1110, 7'b0000000, 1'b1, 2'd0);
    run("s1", 4, 4'b1101, 7'b1000110, 1'b1, 2'd1);
    run("s2", 4, 4'b1011, 7'b0100100, 1'b1, 2'd2);
    run("s3", 4, 4'b0111, 7'b1111001, 1'b1, 2'd3);
    run("s0b", 4, 4'b1110, 7'b0000000, 1'b1, 2'd0);

    // 3: leading-zero blanking
    blank_lz = 1'b1;
    value = 16'h0005;
    update = 1'b1;
    step();
    chk_out("lz_old", 4'b1101, 7'b1000110, 1'b1, 2'd1);
    update = 1'b0;
    run("lz1", 3, AB, SB, 1'b1, 2'd1);
    run("lz2", 4, AB, SB, 1'b1, 2'd2);
    run("lz3", 4, AB, SB, 1'b1, 2'd3);
    run("lz0", 4, 4'b1110, 7'b0010010, 1'b1, 2'd0);
    value = 16'h0000;
    update = 1'b1;
    step();
    chk_out("z1a", AB, SB, 1'b1, 2'd1);
    update = 1'b0;
    run("z1", 3, AB, SB, 1'b1, 2'd1);
    run("z2", 4, AB, SB, 1'b1, 2'd2);
    run("z3", 4, AB, SB, 1'b1, 2'd3);
    run("z0", 4, 4'b1110, 7'b1000000, 1'b1, 2'd0);

    // 4: value change without update is ignored
    blank_lz = 1'b0;
    value = 16'hFFFF;
    run("nu1", 4, 4'b1101, 7'b1000000, 1'b1, 2'd1);
    run("nu2", 4, 4'b1011, 7'b1000000, 1'b1, 2'd2);
    run("nu3", 4, 4'b0111, 7'b1000000, 1'b1, 2'd3);
    run("nu0", 3, 4'b1110, 7'b1000000, 1'b1, 2'd0);
    update = 1'b1;
    step();
    chk_out("wrap_upd", 4'b1110, 7'b1000000, 1'b1, 2'd0);
    update = 1'b0;
    step();
    chk_out("wrap_new", 4'b1101, 7'b0001110, 1'b1, 2'd1);

    // 5: decimal point and enable
    dp_en = 4'b0100;
    run("dp1", 3, 4'b1101, 7'b0001110, 1'b1, 2'd1);
    run("dp2", 4, 4'b1011, 7'b0001110, 1'b0, 2'd2);
    run("dp3", 4, 4'b0111, 7'b0001110, 1'b1, 2'd3);
    en = 1'b0;
    step();
    chk_out("en0", AB, SB, 1'b1, 2'd0);
    en = 1'b1;
    run("en1", 3, 4'b1110, 7'b0001110, 1'b1, 2'd0);
    run("r1", 4, 4'b1101, 7'b0001110, 1'b1, 2'd1);
    step();
    chk_out("r2", 4'b1011, 7'b0001110, 1'b0, 2'd2);

    // 6: asynchronous reset mid-scan
    reset = 1'b1;
    #1;
    chk_out("arst", AB, SB, 1'b1, 2'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run("post0", 4, 4'b1110, 7'b1000000, 1'b1, 2'd0);
    step();
    chk_out("post1", 4'b1101, 7'b1000000, 1'b1, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
